ece429_fetch_queue: RTL and testbench

Parametrised successor to the single-word fetch stage. Issues sequential word reads to the instruction memory (fixed read latency), buffers returned instructions with their PCs in a DEPTH-entry prefetch FIFO, and hands them to decode over a valid/ready handshake. Supports branch redirect with flush and in-flight kill, and a fetch limit for end-of-program stop. Sits between the SREC-loaded memory and the decode stage; fetching starts once the loader signals completion.

---
 rtl/ece429_fetch_queue.sv | 215 +++++++++++++++++++++
 tb/tb_ece429_fetch_queue.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ece429_fetch_queue.sv
// ece429_fetch_queue
//   Prefetching instruction fetch stage. Issues sequential word reads to a
//   fixed-latency instruction memory, buffers the returned instructions with
//   their PCs in a DEPTH-entry FIFO and presents the FIFO head to decode over
//   a valid/ready handshake. Supports branch redirect (flush + kill of
//   in-flight reads) and an inclusive fetch limit for end-of-program stop.
//
//   Optional build macro: FETCH_PERF_EN enables saturating issue/kill/stall
//   counters; without it the perf outputs are tied to zero.
//
//   Ports:
//     clock, reset            clock, asynchronous active-high reset
//     start_in                pulse: leave IDLE and begin fetching
//     limit_in                last fetchable address (inclusive)
//     redirect_in/_pc_in      branch redirect request and target
//     mem_*                   memory request side (read-only, word size)
//     mem_data_in             read data, MEM_LATENCY cycles after issue
//     dec_valid/ready/insn/pc decode handshake on the FIFO head
//     done_out, error_out     sticky completion / misaligned-redirect flags
//     perf_*_out              performance counters (FETCH_PERF_EN)

module ece429_fetch_queue #(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned MEM_LATENCY = 1,
   parameter logic [31:0] RESET_PC    = 32'h8002_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start_in,
   input  logic [31:0] limit_in,
   input  logic        redirect_in,
   input  logic [31:0] redirect_pc_in,
   output logic [31:0] mem_addr_out,
   output logic        mem_req_out,
   output logic        mem_rw_out,
   output logic [1:0]  mem_access_size_out,
   input  logic [31:0] mem_data_in,
   output logic        dec_valid_out,
   input  logic        dec_ready_in,
   output logic [31:0] dec_insn_out,
   output logic [31:0] dec_pc_out,
   output logic        done_out,
   output logic        error_out,
   output logic [31:0] perf_issue_out,
   output logic [31:0] perf_kill_out,
   output logic [31:0] perf_stall_out
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] HALT = 2'd2;

   logic [1:0]             state;
   logic [31:0]            pc;
   logic [31:0]            lastAddr;
   logic                   doneReg;
   logic                   errorReg;

   logic [31:0]            fifoInsn [DEPTH];
   logic [31:0]            fifoPc   [DEPTH];
   logic [PTR_W-1:0]       rdPtr;
   logic [PTR_W-1:0]       wrPtr;
   logic [PTR_W:0]         fifoCount;

   logic [MEM_LATENCY-1:0] pipeValid;
   logic [MEM_LATENCY-1:0] pipeKill;
   logic [31:0]            pipePc [MEM_LATENCY];

   logic [3:0]             inflight;
   logic                   redirectRun;
   logic                   redirectBad;
   logic                   issue;
   logic                   drained;
   logic                   exitValid;
   logic                   exitKill;
   logic                   push;
   logic                   pop;
   logic                   decValid;

   // Only live (non-killed) reads hold a FIFO credit; killed ones never push.
   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
         if (pipeValid[i] && !pipeKill[i]) inflight = inflight + 4'd1;
      end
   end

   assign redirectRun = (state == RUN) && redirect_in;
   assign redirectBad = redirectRun && (redirect_pc_in[1:0] != 2'b00);
   assign issue       = (state == RUN) && !redirect_in && (pc <= limit_in) &&
                        ((32'(fifoCount) + 32'(inflight)) < DEPTH);
   assign drained     = (pc > limit_in) && (inflight == 4'd0) && (fifoCount == '0);
   assign exitValid   = pipeValid[MEM_LATENCY-1];
   assign exitKill    = pipeKill[MEM_LATENCY-1];
   // A response landing in a redirect cycle belongs to the old stream.
   assign push        = exitValid && !exitKill && !redirectRun;
   assign decValid    = (fifoCount != '0);
   assign pop         = decValid && dec_ready_in;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         lastAddr <= RESET_PC;
         doneReg  <= 1'b0;
         errorReg <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start_in) state <= RUN;
            RUN: begin
               if (redirectRun) begin
                  if (redirectBad) begin
                     state    <= HALT;
                     errorReg <= 1'b1;
                  end else begin
                     pc <= redirect_pc_in;
                  end
               end else if (issue) begin
                  pc       <= pc + 32'd4;
                  lastAddr <= pc;
               end else if (drained) begin
                  state   <= HALT;
                  doneReg <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Read pipe: stage MEM_LATENCY-1 lines up with valid mem_data_in.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pipeValid <= '0;
         pipeKill  <= '0;
         for (int unsigned i = 0; i < MEM_LATENCY; i++) pipePc[i] <= '0;
      end else begin
         for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
            pipeValid[i] <= pipeValid[i-1];
            pipeKill[i]  <= pipeKill[i-1] | redirectRun;
            pipePc[i]    <= pipePc[i-1];
         end
         pipeValid[0] <= issue;
         pipeKill[0]  <= 1'b0;
         pipePc[0]    <= pc;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rdPtr     <= '0;
         wrPtr     <= '0;
         fifoCount <= '0;
      end else if (redirectRun) begin
         rdPtr     <= '0;
         wrPtr     <= '0;
         fifoCount <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         case ({push, pop})
            2'b10:   fifoCount <= fifoCount + 1'b1;
            2'b01:   fifoCount <= fifoCount - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifoInsn[wrPtr] <= mem_data_in;
         fifoPc[wrPtr]   <= pipePc[MEM_LATENCY-1];
      end
   end

   assign mem_addr_out        = issue ? pc : lastAddr;
   assign mem_req_out         = issue;
   assign mem_rw_out          = 1'b0;
   assign mem_access_size_out = 2'b00;
   assign dec_valid_out       = decValid;
   assign dec_insn_out        = decValid ? fifoInsn[rdPtr] : '0;
   assign dec_pc_out          = decValid ? fifoPc[rdPtr] : '0;
   assign done_out            = doneReg;
   assign error_out           = errorReg;

`ifdef FETCH_PERF_EN
   logic [31:0] perfIssue;
   logic [31:0] perfKill;
   logic [31:0] perfStall;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         perfIssue <= '0;
         perfKill  <= '0;
         perfStall <= '0;
      end else begin
         if (issue && (perfIssue != '1)) perfIssue <= perfIssue + 32'd1;
         if (exitValid && (exitKill || redirectRun) && (perfKill != '1))
            perfKill <= perfKill + 32'd1;
         if (decValid && !dec_ready_in && (perfStall != '1)) perfStall <= perfStall + 32'd1;
      end
   end

   assign perf_issue_out = perfIssue;
   assign perf_kill_out  = perfKill;
   assign perf_stall_out = perfStall;
`else
   assign perf_issue_out = '0;
   assign perf_kill_out  = '0;
   assign perf_stall_out = '0;
`endif

endmodule

// File: tb/tb_ece429_fetch_queue.sv
module tb_ece429_fetch_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned LAT   = 3;
   localparam logic [31:0] RPC   = 32'h8002_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic        start_in;
   logic [31:0] limit_in;
   logic        redirect_in;
   logic [31:0] redirect_pc_in;
   logic [31:0] mem_addr_out;
   logic        mem_req_out;
   logic        mem_rw_out;
   logic [1:0]  mem_access_size_out;
   logic [31:0] mem_data_in;
   logic        dec_valid_out;
   logic        dec_ready_in;
   logic [31:0] dec_insn_out;
   logic [31:0] dec_pc_out;
   logic        done_out;
   logic        error_out;
   logic [31:0] perf_issue_out;
   logic [31:0] perf_kill_out;
   logic [31:0] perf_stall_out;

   always #5 clock = ~clock;

   ece429_fetch_queue #(.DEPTH(DEPTH), .MEM_LATENCY(LAT), .RESET_PC(RPC)) dut (
      .clock(clock), .reset(reset), .start_in(start_in), .limit_in(limit_in),
      .redirect_in(redirect_in), .redirect_pc_in(redirect_pc_in),
      .mem_addr_out(mem_addr_out), .mem_req_out(mem_req_out), .mem_rw_out(mem_rw_out),
      .mem_access_size_out(mem_access_size_out), .mem_data_in(mem_data_in),
      .dec_valid_out(dec_valid_out), .dec_ready_in(dec_ready_in),
      .dec_insn_out(dec_insn_out), .dec_pc_out(dec_pc_out),
      .done_out(done_out), .error_out(error_out),
      .perf_issue_out(perf_issue_out), .perf_kill_out(perf_kill_out),
      .perf_stall_out(perf_stall_out)
   );

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] salt;

   function automatic logic [31:0] insnOf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ salt;
   endfunction

   // Memory: fixed-latency read pipe, garbage when no read lands.
   bit          reqLatch;
   logic [31:0] addrLatch;
   bit          dReq  [LAT];
   logic [31:0] dAddr [LAT];

   always @(negedge clock) begin
      reqLatch  <= mem_req_out;
      addrLatch <= mem_addr_out;
   end

   always @(posedge clock) begin
      dReq[0]  <= reqLatch;
      dAddr[0] <= addrLatch;
      for (int k = 1; k < LAT; k++) begin
         dReq[k]  <= dReq[k-1];
         dAddr[k] <= dAddr[k-1];
      end
   end

   assign mem_data_in = dReq[LAT-1] ? insnOf(dAddr[LAT-1]) : 32'hDEAD_BEEF;

   // Reference model: outstanding reads with the cycle they become visible.
   typedef struct {
      logic [31:0] pc;
      int          vis;
   } ent_t;

   ent_t        pending[$];
   int          killExit[$];
   int          now;
   int          mState;     // 0 idle, 1 run, 2 halted
   logic [31:0] mPc;
   logic [31:0] mLast;
   logic        mDone;
   logic        mErr;
   int          mIssue;
   int          mStall;
   int          obsIssues;
   int          obsDeliv;
   logic [31:0] lastDelivPc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int killsBefore(input int t);
      int n = 0;
      foreach (killExit[i]) if (killExit[i] < t) n++;
      return n;
   endfunction

   task automatic modelReset();
      pending.delete();
      killExit.delete();
      mState = 0;
      mPc    = RPC;
      mLast  = RPC;
      mDone  = 1'b0;
      mErr   = 1'b0;
      mIssue = 0;
      mStall = 0;
   endtask

   task automatic cycle();
      logic expValid, expReq, emptyNow;
      ent_t e;
      @(negedge clock);
      expValid = (pending.size() > 0) && (pending[0].vis <= now);
      expReq   = (mState == 1) && !redirect_in && (mPc <= limit_in) && (pending.size() < DEPTH);
      chk("mem_req", 32'(mem_req_out), 32'(expReq));
      chk("mem_addr", mem_addr_out, expReq ? mPc : mLast);
      chk("mem_rw", 32'(mem_rw_out), 32'd0);
      chk("mem_size", 32'(mem_access_size_out), 32'd0);
      chk("dec_valid", 32'(dec_valid_out), 32'(expValid));
      if (expValid) begin
         chk("dec_pc", dec_pc_out, pending[0].pc);
         chk("dec_insn", dec_insn_out, insnOf(pending[0].pc));
      end else begin
         chk("dec_pc_idle", dec_pc_out, 32'd0);
         chk("dec_insn_idle", dec_insn_out, 32'd0);
      end
      chk("done", 32'(done_out), 32'(mDone));
      chk("error", 32'(error_out), 32'(mErr));
`ifdef FETCH_PERF_EN
      chk("perf_issue", perf_issue_out, 32'(mIssue));
      chk("perf_kill", perf_kill_out, 32'(killsBefore(now)));
      chk("perf_stall", perf_stall_out, 32'(mStall));
`else
      chk("perf_issue", perf_issue_out, 32'd0);
      chk("perf_kill", perf_kill_out, 32'd0);
      chk("perf_stall", perf_stall_out, 32'd0);
`endif
      if (mem_req_out) obsIssues++;
      if (dec_valid_out && dec_ready_in) begin
         obsDeliv++;
         lastDelivPc = dec_pc_out;
      end
      emptyNow = (pending.size() == 0);
      if (expValid && !dec_ready_in) mStall++;
      if (expValid && dec_ready_in) void'(pending.pop_front());
      case (mState)
         0: if (start_in) mState = 1;
         1: begin
            if (redirect_in) begin
               foreach (pending[i]) if (pending[i].vis - 1 >= now) killExit.push_back(pending[i].vis - 1);
               pending.delete();
               if (redirect_pc_in[1:0] != 2'b00) begin
                  mState = 2;
                  mErr   = 1'b1;
               end else begin
                  mPc = redirect_pc_in;
               end
            end else if (expReq) begin
               e.pc  = mPc;
               e.vis = now + int'(LAT) + 1;
               pending.push_back(e);
               mLast = mPc;
               mPc   = mPc + 32'd4;
               mIssue++;
            end else if ((mPc > limit_in) && emptyNow) begin
               mState = 2;
               mDone  = 1'b1;
            end
         end
         default: ;
      endcase
      now++;
      @(posedge clock);
      #1;
   endtask

   task automatic doReset();
      reset       = 1'b1;
      start_in    = 1'b0;
      redirect_in = 1'b0;
      modelReset();
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int  guard;
      logic reached;
      salt           = $urandom;
      now            = 0;
      obsIssues      = 0;
      obsDeliv       = 0;
      lastDelivPc    = '0;
      redirect_pc_in = '0;
      limit_in       = RPC + 32'h1C;
      dec_ready_in   = 1'b1;
      doReset();

      // Straight-line program of 8 words; start and redirect together in IDLE.
      cycle();
      start_in = 1'b1; redirect_in = 1'b1; redirect_pc_in = RPC + 32'h40;
      cycle();
      start_in = 1'b0; redirect_in = 1'b0;
      guard = 0;
      while (!done_out && guard < 80) begin cycle(); guard++; end
      chk("A_done", 32'(done_out), 32'd1);
      chk("A_issues", 32'(obsIssues), 32'd8);
      chk("A_deliv", 32'(obsDeliv), 32'd8);
      redirect_in = 1'b1; redirect_pc_in = RPC;   // ignored in HALT
      cycle();
      redirect_in = 1'b0;
      repeat (3) cycle();

      // Decode stalled: credit limits issue to DEPTH, then in-order release.
      doReset();
      limit_in = RPC + 32'h3FC;
      dec_ready_in = 1'b0;
      start_in = 1'b1;
      cycle();
      start_in = 1'b0;
      obsIssues = 0;
      repeat (20) cycle();
      chk("B_issues_stalled", 32'(obsIssues), 32'(DEPTH));
      dec_ready_in = 1'b1;
      repeat (20) cycle();
      repeat (80) begin
         dec_ready_in = ($urandom_range(0, 3) != 0);
         cycle();
      end

      // Redirect after two issues kills both in-flight reads.
      dec_ready_in = 1'b1;
      doReset();
      limit_in = RPC + 32'hFFC;
      start_in = 1'b1;
      cycle();
      start_in = 1'b0;
      obsIssues = 0;
      guard = 0;
      while (obsIssues < 2 && guard < 20) begin cycle(); guard++; end
      chk("C_two_issues", 32'(obsIssues), 32'd2);
      redirect_in = 1'b1; redirect_pc_in = RPC + 32'h100;
      cycle();
      redirect_in = 1'b0;
      obsDeliv = 0;
      guard = 0;
      while (obsDeliv == 0 && guard < 30) begin cycle(); guard++; end
      chk("C_first_pc", lastDelivPc, RPC + 32'h100);
`ifdef FETCH_PERF_EN
      chk("C_kills", perf_kill_out, 32'd2);
`else
      chk("C_kills", perf_kill_out, 32'd0);
`endif

      // Misaligned redirect: error, halt, no further reads.
      redirect_in = 1'b1; redirect_pc_in = RPC + 32'h102;
      cycle();
      redirect_in = 1'b0;
      obsIssues = 0;
      repeat (10) cycle();
      chk("D_error", 32'(error_out), 32'd1);
      chk("D_no_issue", 32'(obsIssues), 32'd0);

      // Asynchronous reset with 3 buffered entries and 1 read in flight.
      doReset();
      dec_ready_in = 1'b0;
      start_in = 1'b1;
      cycle();
      start_in = 1'b0;
      reached = 1'b0;
      guard = 0;
      while (!reached && guard < 20) begin
         cycle();
         guard++;
         reached = (pending.size() == 4) && (pending[2].vis <= now) && (pending[3].vis > now);
      end
      chk("F_reached", 32'(reached), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("F_mem_req", 32'(mem_req_out), 32'd0);
      chk("F_mem_addr", mem_addr_out, RPC);
      chk("F_valid", 32'(dec_valid_out), 32'd0);
      chk("F_insn", dec_insn_out, 32'd0);
      chk("F_pc", dec_pc_out, 32'd0);
      chk("F_done", 32'(done_out), 32'd0);
      chk("F_perf", perf_issue_out, 32'd0);
      modelReset();
      @(posedge clock);
      #1 reset = 1'b0;
      dec_ready_in = 1'b1;
      obsDeliv = 0;
      repeat (10) cycle();
      chk("F_no_push", 32'(obsDeliv), 32'd0);

      // Random decode back-pressure, stray starts and aligned redirects.
      doReset();
      limit_in = RPC + 32'($urandom_range(20, 40)) * 32'd4;
      start_in = 1'b1;
      cycle();
      start_in = 1'b0;
      guard = 0;
      while (!done_out && guard < 500) begin
         dec_ready_in = ($urandom_range(0, 2) != 0);
         start_in     = ($urandom_range(0, 7) == 0);
         redirect_in  = (guard < 150) && ($urandom_range(0, 15) == 0);
         redirect_pc_in = RPC + 32'($urandom_range(0, 30)) * 32'd4;
         cycle();
         guard++;
      end
      start_in = 1'b0; redirect_in = 1'b0;
      chk("G_done", 32'(done_out), 32'd1);
      repeat (3) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
